imem_access_ctrl: RTL and testbench
===================================

// Module: imem_access_ctrl
// PURPOSE
//  Sequences all accesses to the byte-wide, single-port instruction memory (synchronous read).
//  Arbitrates between two requesters:
//   - fetch: 32-bit instruction reads at the PC
//   - loader: 32-bit program writes
//  Each word is split into four little-endian byte beats.
//  Sits between the PC register / loader port and the instruction byte array.
//  Replaces the array's initial-block programming path.
// PARAMETERS
//  MEM_BYTES  44                      instruction memory size in bytes
//  IDX_W      $clog2(MEM_BYTES)       byte index width driven to memory
//  NOP_INSTR  32'h0000_0013           word returned on fetch error (addi x0,x0,0)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  f_req_valid  in   1      fetch request
//  f_req_ready  out  1      fetch request accepted this cycle
//  f_addr       in   32     fetch byte address (PC)
//  f_rsp_valid  out  1      one-cycle pulse: f_rsp_instr/f_rsp_err valid
//  f_rsp_instr  out  32     assembled instruction {b3,b2,b1,b0}
//  f_rsp_err    out  1      misaligned or out-of-range fetch
//  l_req_valid  in   1      loader write request
//  l_req_ready  out  1      loader request accepted this cycle
//  l_addr       in   32     loader byte address
//  l_wdata      in   32     loader word
//  l_done       out  1      one-cycle pulse: write finished (or rejected)
//  l_err        out  1      qualifies l_done: misaligned/out-of-range, nothing written
//  mem_en       out  1      memory access strobe
//  mem_we       out  1      1 = byte write, 0 = byte read
//  mem_addr     out  IDX_W  byte index
//  mem_wdata    out  8      write byte
//  mem_rdata    in   8      read byte, valid the cycle after a read strobe
// BEHAVIOUR
//  Reset values: all outputs 0; FSM = IDLE; rr_last = LOADER (fetch wins first tie).
//  Handshake
//   - Transfer on the rising edge with valid & ready.
//   - ready is combinational, asserted only in IDLE, for at most one requester.
//   - Address and data are latched at accept; requesters need not hold them.
//  Arbitration (both valid in IDLE)
//   - Round-robin: grant the requester not in rr_last.
//   - rr_last updates on every accept.
//   - A single valid requester always wins.
//   - No preemption mid-word.
//  Check at accept
//   - err = (addr[1:0] != 0) | (addr + 3 >= MEM_BYTES).
//   - Use 33-bit compare; no wrap-around at 32'hFFFF_FFFC.
//   - Error → ERR state: no memory strobe.
//   - Pulse f_rsp_valid+f_rsp_err (instr = NOP_INSTR) or l_done+l_err one cycle after accept.
//  States: IDLE, RD(beat 0..3), RD_LAST, WR(beat 0..3), RESP, ERR
//   - IDLE  → RD | WR | ERR on accept.
//   - RD k  : mem_en=1, mem_we=0, mem_addr=base+k; byte k-1 captured from mem_rdata (k>0).
//   - RD_LAST: capture byte 3.
//   - WR k  : mem_en=1, mem_we=1, mem_addr=base+k, mem_wdata=wdata[8k+7:8k].
//   - RESP  : registered pulse f_rsp_valid (read) or l_done (write).
//   - RESP, ERR → IDLE.
//  Latency, counted in cycles after the accept edge
//   - Read: rsp in the 6th cycle.
//   - Write: done in the 5th cycle.
//   - Error: in the 1st cycle.
//   - ready is low in RD/WR/RESP/ERR.
//   - Next accept no earlier than the cycle after the pulse.
//  f_rsp_instr holds its value until the next fetch response; l_err/f_rsp_err are meaningful only with their pulse.
//  Reset mid-operation
//   - Abort immediately; no response is issued.
//   - Bytes already written stay in memory (partial word); the loader must rewrite.
//  mem_en=0 in IDLE/RESP/ERR; mem_addr/mem_wdata are don't-care when mem_en=0.
// STRUCTURE
//  riscv_pkg additions:
//   - imem_state_e: IDLE, RD, RD_LAST, WR, RESP, ERR
//   - imem_req_e: FETCH, LOADER
//   - localparam IMEM_BYTES = 44
//   - localparam NOP_INSTR
//  Sub-module: imem_rr_arb (2-way round-robin: valid[1:0], accept → grant[1:0], rr_last); the rest is a single FSM + 2-bit beat counter.
// TESTING
//  - Load 32'h00100113 at 0 → 4 write strobes at 0..3 with bytes 13,01,10,00; l_done in 5th cycle; then fetch 0 → f_rsp_instr=32'h00100113, err=0, 6th cycle.
//  - Fetch and loader valid in the same cycle right after reset → fetch granted first; loader next; alternate over 4 tied rounds.
//  - Fetch 0x02 (misaligned) and 0x2C (out of range) → next-cycle f_rsp_err=1, instr=32'h00000013, mem_en never high.
//  - Fetch 0x28 (last valid word, bytes 0x28..0x2B) → success; loader 0xFFFFFFFC → l_err=1, no write.
//  - Assert rst during WR beat 2 of word 32'hAABBCCDD at 8 → outputs 0 at once; bytes 8,9 hold DD,CC; 10,11 unchanged; no l_done.
//  - Back-to-back fetch with f_req_valid held high → accepts spaced 7 cycles apart; never both readies high (assertion).

Source files
------------

// File: rtl/imem_access_ctrl_pkg.sv
// Shared types and constants for the instruction-memory access controller.
//   imem_state_e : controller FSM states
//   imem_req_e   : requester identity (fetch port or loader port)
//   IMEM_BYTES   : instruction memory size in bytes
//   NOP_INSTR    : word returned on a rejected fetch (addi x0,x0,0)
//   addr_err()   : word-access legality check, done on a 33-bit sum so the
//                  top of the address space cannot wrap back into range
package imem_access_ctrl_pkg;

    localparam int unsigned IMEM_BYTES = 44;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_LAST,
        WR,
        RESP,
        ERR
    } imem_state_e;

    typedef enum logic {
        FETCH  = 1'b0,
        LOADER = 1'b1
    } imem_req_e;

    function automatic logic addr_err(input logic [31:0] addr, input int unsigned mem_bytes);
        return (addr[1:0] != 2'b00) || (({1'b0, addr} + 33'd3) >= 33'(mem_bytes));
    endfunction

endpackage

// File: rtl/imem_rr_arb.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   valid    : [0] fetch request, [1] loader request (already gated by caller)
//   accept   : a grant was taken this cycle; advances the round-robin pointer
//   grant    : one-hot (or zero) grant, combinational from valid
module imem_rr_arb
    import imem_access_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    imem_req_e rr_last_q;
    imem_req_e rr_last_d;

    always_comb begin
        grant = valid;
        // On a tie, the requester that did not win last time goes first.
        if (valid == 2'b11) begin
            grant = (rr_last_q == FETCH) ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (accept) begin
            rr_last_d = grant[1] ? LOADER : FETCH;
        end
    end

    // Resetting to LOADER lets fetch win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q <= LOADER;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/imem_access_ctrl.sv
// Instruction-memory access controller: arbitrates fetch reads and loader
// writes onto a byte-wide single-port synchronous-read memory, splitting each
// 32-bit word into four little-endian byte beats.
//   f_req_*/f_addr   : fetch request handshake and byte address
//   f_rsp_*          : one-cycle fetch response pulse, instruction, error flag
//   l_req_*/l_addr/l_wdata : loader write request handshake, address, word
//   l_done/l_err     : one-cycle write completion pulse and error qualifier
//   mem_*            : byte memory strobe, direction, index, write/read data
module imem_access_ctrl
    import imem_access_ctrl_pkg::*;
#(
    parameter int unsigned MEM_BYTES = IMEM_BYTES,
    parameter int unsigned IDX_W     = $clog2(MEM_BYTES),
    parameter logic [31:0] NOP_INSTR = imem_access_ctrl_pkg::NOP_INSTR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_req_valid,
    output logic             f_req_ready,
    input  logic [31:0]      f_addr,
    output logic             f_rsp_valid,
    output logic [31:0]      f_rsp_instr,
    output logic             f_rsp_err,
    input  logic             l_req_valid,
    output logic             l_req_ready,
    input  logic [31:0]      l_addr,
    input  logic [31:0]      l_wdata,
    output logic             l_done,
    output logic             l_err,
    output logic             mem_en,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_addr,
    output logic [7:0]       mem_wdata,
    input  logic [7:0]       mem_rdata
);

    imem_state_e      state_q, state_d;
    imem_req_e        req_q, req_d;
    logic [1:0]       beat_q, beat_d;
    logic [IDX_W-1:0] base_q, base_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [23:0]      buf_q, buf_d;     // bytes 0..2; byte 3 goes straight into instr
    logic [31:0]      instr_q, instr_d;

    logic [1:0]  arb_valid;
    logic [1:0]  grant;
    logic        accept;
    logic [31:0] sel_addr;
    logic        sel_err;

    // Requests are only visible to the arbiter while idle, so ready is never
    // raised mid-word and at most one ready is high.
    assign arb_valid = (state_q == IDLE) ? {l_req_valid, f_req_valid} : 2'b00;
    assign accept    = |grant;

    imem_rr_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid  (arb_valid),
        .accept (accept),
        .grant  (grant)
    );

    assign f_req_ready = grant[0];
    assign l_req_ready = grant[1];
    assign sel_addr    = grant[1] ? l_addr : f_addr;
    assign sel_err     = addr_err(sel_addr, MEM_BYTES);

    // Responses are decoded from registered state, so they are clean pulses.
    assign f_rsp_valid = (req_q == FETCH)  && ((state_q == RESP) || (state_q == ERR));
    assign f_rsp_err   = (req_q == FETCH)  && (state_q == ERR);
    assign l_done      = (req_q == LOADER) && ((state_q == RESP) || (state_q == ERR));
    assign l_err       = (req_q == LOADER) && (state_q == ERR);
    assign f_rsp_instr = instr_q;

    assign mem_en   = (state_q == RD) || (state_q == WR);
    assign mem_we   = (state_q == WR);
    assign mem_addr = base_q + IDX_W'(beat_q);

    always_comb begin
        mem_wdata = 8'h00;
        case (beat_q)
            2'd0: mem_wdata = wdata_q[7:0];
            2'd1: mem_wdata = wdata_q[15:8];
            2'd2: mem_wdata = wdata_q[23:16];
            2'd3: mem_wdata = wdata_q[31:24];
            default: mem_wdata = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        beat_d  = beat_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        buf_d   = buf_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d   = grant[1] ? LOADER : FETCH;
                    base_d  = sel_addr[IDX_W-1:0];
                    wdata_d = l_wdata;
                    beat_d  = 2'd0;
                    if (sel_err) begin
                        state_d = ERR;
                        // Loaded now so the NOP is visible with the error pulse
                        // and then held like any other fetch response.
                        if (!grant[1]) begin
                            instr_d = NOP_INSTR;
                        end
                    end else begin
                        state_d = grant[1] ? WR : RD;
                    end
                end
            end
            RD: begin
                // Synchronous read: the byte strobed last cycle arrives now.
                case (beat_q)
                    2'd1: buf_d[7:0]   = mem_rdata;
                    2'd2: buf_d[15:8]  = mem_rdata;
                    2'd3: buf_d[23:16] = mem_rdata;
                    default: ;
                endcase
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = RD_LAST;
                end
            end
            RD_LAST: begin
                // Instruction updates only at completion so the output holds
                // the previous response throughout the read.
                instr_d = {mem_rdata, buf_q};
                state_d = RESP;
            end
            WR: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = RESP;
                end
            end
            RESP, ERR: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= FETCH;
            beat_q  <= 2'd0;
            base_q  <= '0;
            wdata_q <= 32'h0;
            buf_q   <= 24'h0;
            instr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            instr_q <= instr_d;
        end
    end

endmodule

// File: tb/tb_imem_access_ctrl.sv
module tb_imem_access_ctrl;

    localparam int MEMB  = 44;
    localparam int IDX_W = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             f_req_valid = 1'b0;
    logic             f_req_ready;
    logic [31:0]      f_addr = 32'h0;
    logic             f_rsp_valid;
    logic [31:0]      f_rsp_instr;
    logic             f_rsp_err;
    logic             l_req_valid = 1'b0;
    logic             l_req_ready;
    logic [31:0]      l_addr = 32'h0;
    logic [31:0]      l_wdata = 32'h0;
    logic             l_done;
    logic             l_err;
    logic             mem_en;
    logic             mem_we;
    logic [IDX_W-1:0] mem_addr;
    logic [7:0]       mem_wdata;
    logic [7:0]       mem_rdata = 8'h00;

    int tests = 0;
    int fails = 0;

    imem_access_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .f_req_valid (f_req_valid),
        .f_req_ready (f_req_ready),
        .f_addr      (f_addr),
        .f_rsp_valid (f_rsp_valid),
        .f_rsp_instr (f_rsp_instr),
        .f_rsp_err   (f_rsp_err),
        .l_req_valid (l_req_valid),
        .l_req_ready (l_req_ready),
        .l_addr      (l_addr),
        .l_wdata     (l_wdata),
        .l_done      (l_done),
        .l_err       (l_err),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Byte memory model: synchronous read, initial contents 0x40+i.
    logic [7:0] mem [0:MEMB-1];
    logic       mem_init = 1'b0;
    int         cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_init) begin
            for (int i = 0; i < MEMB; i++) mem[i] <= 8'(8'h40 + i);
            mem_init <= 1'b1;
        end else if (mem_en && (int'(mem_addr) < MEMB)) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    // Monitors, sampled mid-low-phase.
    logic [13:0] wlog [$];
    bit          acc_who [$];
    int          acc_cyc [$];
    int          en_cnt  = 0;
    int          done_cnt = 0;
    bit          both_hi = 1'b0;
    always @(negedge clk) begin
        #2;
        if (mem_en) en_cnt++;
        if (mem_en && mem_we) wlog.push_back({mem_addr, mem_wdata});
        if (l_done) done_cnt++;
        if (f_req_ready && l_req_ready) both_hi = 1'b1;
        if (f_req_valid && f_req_ready) begin acc_who.push_back(1'b0); acc_cyc.push_back(cyc); end
        if (l_req_valid && l_req_ready) begin acc_who.push_back(1'b1); acc_cyc.push_back(cyc); end
    end

    task automatic run_load(input logic [31:0] a, input logic [31:0] d,
                            output int lat, output logic err, output int nstb);
        int w;
        @(negedge clk);
        l_req_valid = 1'b1; l_addr = a; l_wdata = d;
        #1;
        w = 0;
        while (!l_req_ready && w < 20) begin @(negedge clk); #1; w++; end
        @(posedge clk);
        @(negedge clk);
        l_req_valid = 1'b0; l_addr = 32'hFFFF_FFFF; l_wdata = 32'h5555_5555;
        lat = 1; nstb = 0;
        while (!l_done && lat < 20) begin
            if (mem_en) nstb++;
            @(negedge clk); lat++;
        end
        err = l_err;
    endtask

    task automatic run_fetch(input logic [31:0] a, output int lat,
                             output logic [31:0] instr, output logic err);
        int w;
        @(negedge clk);
        f_req_valid = 1'b1; f_addr = a;
        #1;
        w = 0;
        while (!f_req_ready && w < 20) begin @(negedge clk); #1; w++; end
        @(posedge clk);
        @(negedge clk);
        f_req_valid = 1'b0; f_addr = 32'hFFFF_FFFF;
        lat = 1;
        while (!f_rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        instr = f_rsp_instr; err = f_rsp_err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({f_req_ready, l_req_ready, f_rsp_valid, f_rsp_err, l_done, l_err, mem_en, mem_we} !== 8'h00) begin
            fails++; $display("FAIL reset_ctrl got %b want 00000000",
                {f_req_ready, l_req_ready, f_rsp_valid, f_rsp_err, l_done, l_err, mem_en, mem_we});
        end
        tests++;
        if ({f_rsp_instr, mem_addr, mem_wdata} !== 46'h0) begin
            fails++; $display("FAIL reset_data got instr=%h addr=%h wdata=%h want 0", f_rsp_instr, mem_addr, mem_wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_tie();
        int w;
        acc_who.delete(); acc_cyc.delete();
        f_req_valid = 1'b1; f_addr = 32'h0;
        l_req_valid = 1'b1; l_addr = 32'h4; l_wdata = 32'h1122_3344;
        #1;
        tests++;
        if ({f_req_ready, l_req_ready} !== 2'b10) begin
            fails++; $display("FAIL tie_first_ready got %b want 10", {f_req_ready, l_req_ready});
        end
        w = 0;
        while (acc_who.size() < 4 && w < 100) begin @(negedge clk); #3; w++; end
        f_req_valid = 1'b0; l_req_valid = 1'b0;
        repeat (8) @(negedge clk);
        tests++;
        if (acc_who.size() < 4) begin
            fails++; $display("FAIL tie_accepts got %0d want 4", acc_who.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (acc_who[i] !== bit'(i % 2)) begin
                    fails++; $display("FAIL tie_order[%0d] got %0d want %0d", i, acc_who[i], i % 2);
                end
            end
        end
    endtask

    task automatic test_load_fetch();
        int lat, nstb; logic err; logic [31:0] instr;
        logic [13:0] exp_w [4];
        exp_w[0] = {6'd0, 8'h13}; exp_w[1] = {6'd1, 8'h01};
        exp_w[2] = {6'd2, 8'h10}; exp_w[3] = {6'd3, 8'h00};
        wlog.delete();
        run_load(32'h0, 32'h0010_0113, lat, err, nstb);
        tests++;
        if (lat !== 5 || err !== 1'b0 || nstb !== 4) begin
            fails++; $display("FAIL load0 got lat=%0d err=%b strobes=%0d want 5 0 4", lat, err, nstb);
        end
        tests++;
        if (wlog.size() != 4) begin
            fails++; $display("FAIL load0_wlog got %0d writes want 4", wlog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wlog[i] !== exp_w[i]) begin
                    fails++; $display("FAIL load0_byte[%0d] got %h want %h", i, wlog[i], exp_w[i]);
                end
            end
        end
        run_fetch(32'h0, lat, instr, err);
        tests++;
        if (lat !== 6 || instr !== 32'h0010_0113 || err !== 1'b0) begin
            fails++; $display("FAIL fetch0 got lat=%0d instr=%h err=%b want 6 00100113 0", lat, instr, err);
        end
    endtask

    task automatic test_errors();
        int lat, nstb, en0; logic err; logic [31:0] instr;
        en0 = en_cnt;
        run_fetch(32'h2, lat, instr, err);
        tests++;
        if (lat !== 1 || err !== 1'b1 || instr !== 32'h0000_0013) begin
            fails++; $display("FAIL fetch_misalign got lat=%0d err=%b instr=%h want 1 1 00000013", lat, err, instr);
        end
        run_fetch(32'h2C, lat, instr, err);
        tests++;
        if (lat !== 1 || err !== 1'b1 || instr !== 32'h0000_0013) begin
            fails++; $display("FAIL fetch_range got lat=%0d err=%b instr=%h want 1 1 00000013", lat, err, instr);
        end
        @(negedge clk);
        tests++;
        if (en_cnt !== en0) begin
            fails++; $display("FAIL err_no_strobe got %0d strobes want 0", en_cnt - en0);
        end
        run_load(32'h28, 32'hCAFE_F00D, lat, err, nstb);
        run_fetch(32'h28, lat, instr, err);
        tests++;
        if (lat !== 6 || instr !== 32'hCAFE_F00D || err !== 1'b0) begin
            fails++; $display("FAIL fetch_last got lat=%0d instr=%h err=%b want 6 cafef00d 0", lat, instr, err);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (f_rsp_instr !== 32'hCAFE_F00D) begin
            fails++; $display("FAIL instr_hold got %h want cafef00d", f_rsp_instr);
        end
        wlog.delete();
        run_load(32'hFFFF_FFFC, 32'h1234_5678, lat, err, nstb);
        tests++;
        if (lat !== 1 || err !== 1'b1 || wlog.size() != 0) begin
            fails++; $display("FAIL load_wrap got lat=%0d err=%b writes=%0d want 1 1 0", lat, err, wlog.size());
        end
    endtask

    task automatic test_reset_mid_write();
        int d0, w;
        @(negedge clk);
        l_req_valid = 1'b1; l_addr = 32'h8; l_wdata = 32'hAABB_CCDD;
        #1;
        w = 0;
        while (!l_req_ready && w < 20) begin @(negedge clk); #1; w++; end
        @(posedge clk);
        @(negedge clk);                 // WR beat 0
        l_req_valid = 1'b0;
        @(negedge clk);                 // WR beat 1
        @(negedge clk);                 // WR beat 2
        tests++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'd10) begin
            fails++; $display("FAIL midwr_beat2 got en=%b we=%b addr=%0d want 1 1 10", mem_en, mem_we, mem_addr);
        end
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        tests++;
        if ({f_req_ready, l_req_ready, f_rsp_valid, f_rsp_err, l_done, l_err, mem_en, mem_we, mem_addr, mem_wdata, f_rsp_instr} !== 54'h0) begin
            fails++; $display("FAIL midwr_reset_out got en=%b we=%b addr=%h wdata=%h instr=%h want 0",
                mem_en, mem_we, mem_addr, mem_wdata, f_rsp_instr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        tests++;
        if ({mem[8], mem[9], mem[10], mem[11]} !== 32'hDDCC_4A4B) begin
            fails++; $display("FAIL midwr_mem got %h%h%h%h want ddcc4a4b", mem[8], mem[9], mem[10], mem[11]);
        end
        tests++;
        if (done_cnt !== d0) begin
            fails++; $display("FAIL midwr_no_done got %0d pulses want 0", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        acc_cyc.delete(); acc_who.delete();
        @(negedge clk);
        f_req_valid = 1'b1; f_addr = 32'h0;
        w = 0;
        while (acc_cyc.size() < 3 && w < 60) begin @(negedge clk); #3; w++; end
        f_req_valid = 1'b0;
        repeat (8) @(negedge clk);
        tests++;
        if (acc_cyc.size() < 3) begin
            fails++; $display("FAIL b2b_accepts got %0d want 3", acc_cyc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                if (acc_cyc[i] - acc_cyc[i-1] !== 7) begin
                    fails++; $display("FAIL b2b_spacing[%0d] got %0d want 7", i, acc_cyc[i] - acc_cyc[i-1]);
                end
            end
        end
        tests++;
        if (both_hi !== 1'b0) begin
            fails++; $display("FAIL both_ready got 1 want 0");
        end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_load_fetch();
        test_errors();
        test_reset_mid_write();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
